// File: rtl/cpu_pkg.sv
// Shared core definitions: NOP encoding, major opcodes and the fetch-pair record
// passed from the fetch queue to decode.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] I_IMM = 7'b0010011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] S     = 7'b0100011;
    localparam logic [6:0] R     = 7'b0110011;
    localparam logic [6:0] B     = 7'b1100011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr1;
        logic [31:0] instr2;
        logic        slot2_ok;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_pair_fifo.sv
// Synchronous FIFO of fetched instruction pairs; flush beats push and pop.
// Storage is cleared on reset so the head reads as an all-zero pair afterwards.
import cpu_pkg::*;

module fetch_pair_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_pair_t   wdata,
    output fetch_pair_t   rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    fetch_pair_t   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != FULL_CNT);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/dual_fetch_unit.sv
// Two-wide instruction fetch front end: PC, ROM request, pair queue and decode handshake.
// Define FETCH_PERF_EN to add the stall/redirect performance counters.
import cpu_pkg::*;

module dual_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10,
    parameter int          FQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] rom_addr,
    input  logic [31:0]        rom_instr1,
    input  logic [31:0]        rom_instr2,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic               id_slot2_valid,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_instr1,
    output logic [31:0]        id_instr2
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_redirect_cnt
`endif
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FQ_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          req_slot2_ok;
    logic          inflight;
    logic          issue;
    logic          pop;
    logic [CW-1:0] q_count;
    logic [CW:0]   credit;
    logic          q_empty;
    fetch_pair_t   push_pair;
    fetch_pair_t   head;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign rom_addr = pc[IMEM_AW+1:2];

    // Credit counts the response already in flight so a push can never overflow.
    assign credit = {1'b0, q_count} + {{CW{1'b0}}, inflight};
    assign issue  = !redirect_valid && (credit < DEPTH_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            req_pc       <= '0;
            req_slot2_ok <= 1'b0;
        end else begin
            inflight <= issue;
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                pc           <= pc + 32'd8;
                req_pc       <= pc;
                req_slot2_ok <= ~&pc[IMEM_AW+1:2];
            end
        end
    end

    assign push_pair.pc       = req_pc;
    assign push_pair.instr1   = rom_instr1;
    assign push_pair.instr2   = rom_instr2;
    assign push_pair.slot2_ok = req_slot2_ok;

    // A redirect flushes the queue, which also drops the response arriving this cycle.
    fetch_pair_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_pair),
        .rdata (head),
        .empty (q_empty),
        .count (q_count)
    );

    assign id_valid       = !q_empty && !redirect_valid;
    assign pop            = id_valid && id_ready;
    assign id_slot2_valid = id_valid && head.slot2_ok;
    assign id_pc          = head.pc;
    assign id_instr1      = id_valid ? head.instr1 : NOP_INSTR;
    assign id_instr2      = id_valid ? head.instr2 : NOP_INSTR;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (id_valid && !id_ready && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid && (perf_redirect_cnt != '1))
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Bench for dual_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model of the fetch rules.
`timescale 1ns/1ps

module tb_dual_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rom_addr;
    logic [31:0] rom_instr1 = '0;
    logic [31:0] rom_instr2 = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic        id_slot2_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr1;
    logic [31:0] id_instr2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    dual_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_instr1     (rom_instr1),
        .rom_instr2     (rom_instr2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_slot2_valid (id_slot2_valid),
        .id_pc          (id_pc),
        .id_instr1      (id_instr1),
        .id_instr2      (id_instr2)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ROM: word i holds 0x1000_0000+i, registered read, second port at addr+1.
    always @(posedge clk) begin
        rom_instr1 <= 32'h1000_0000 + {22'd0, rom_addr};
        rom_instr2 <= 32'h1000_0000 + {22'd0, rom_addr + 10'd1};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc = '0;
    logic [31:0] m_q[$];
    bit          m_pend = 0;
    logic [31:0] m_pend_pc = '0;
    bit          m_on = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_redir = '0;

    function automatic logic [31:0] word_of(input logic [31:0] p, input int ofs);
        logic [9:0] idx;
        idx = p[11:2] + 10'(ofs);
        return 32'h1000_0000 + {22'd0, idx};
    endfunction

    task automatic model_step();
        bit ev;
        int credit;
        if (rst) begin
            m_on = 1;
            m_pc = 32'h0;
            m_q.delete();
            m_pend = 0;
            m_stall = '0;
            m_redir = '0;
            return;
        end
        if (!m_on) return;
        ev = (m_q.size() > 0) && !redirect_valid;
        if (ev && !id_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (redirect_valid) begin
            if (m_redir != 32'hFFFF_FFFF) m_redir++;
            m_q.delete();
            m_pend = 0;
            m_pc = {redirect_pc[31:2], 2'b00};
            return;
        end
        credit = m_q.size() + int'(m_pend);
        if (ev && id_ready) void'(m_q.pop_front());
        if (m_pend) m_q.push_back(m_pend_pc);
        if (credit < DEPTH) begin
            m_pend = 1;
            m_pend_pc = m_pc;
            m_pc = m_pc + 32'd8;
        end else begin
            m_pend = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (m_on) begin
            bit          ev;
            logic [31:0] hp;
            ev = (m_q.size() > 0) && !redirect_valid;
            chk("rom_addr", {22'd0, rom_addr}, {22'd0, m_pc[11:2]});
            chk("id_valid", {31'd0, id_valid}, {31'd0, ev});
            if (ev) begin
                hp = m_q[0];
                chk("id_pc", id_pc, hp);
                chk("id_instr1", id_instr1, word_of(hp, 0));
                chk("id_slot2_valid", {31'd0, id_slot2_valid}, {31'd0, hp[11:2] != 10'h3FF});
                if (hp[11:2] != 10'h3FF) chk("id_instr2", id_instr2, word_of(hp, 1));
            end else begin
                chk("idle_slot2", {31'd0, id_slot2_valid}, 32'd0);
                chk("idle_instr1", id_instr1, NOP);
                chk("idle_instr2", id_instr2, NOP);
            end
`ifdef FETCH_PERF_EN
            chk("perf_stall", perf_stall_cnt, m_stall);
            chk("perf_redirect", perf_redirect_cnt, m_redir);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 after reset.
    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        id_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_slot2", {31'd0, id_slot2_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_instr1", id_instr1, NOP);
        chk("rst_instr2", id_instr2, NOP);
        chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        tick();
        rst = 1'b0;

        // Scenario 1: streaming, one pair per cycle from cycle 2.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 2) chk("s1_early_valid", {31'd0, id_valid}, 32'd0);
            if (c == 2) begin
                chk("s1_instr1", id_instr1, 32'h1000_0000);
                chk("s1_instr2", id_instr2, 32'h1000_0001);
            end
            if (c >= 2) begin
                chk("s1_valid", {31'd0, id_valid}, 32'd1);
                chk("s1_pc", id_pc, 32'((c - 2) * 8));
            end
            tick();
        end

        // Scenario 2: backpressure for 10 cycles, then drain without gaps;
        // continues into a redirect to exercise the perf counters.
        do_reset();
        for (int c = 0; c < 32; c++) begin
            id_ready = !(c >= 2 && c < 12);
            redirect_valid = (c == 20);
            redirect_pc = 32'h40;
            @(negedge clk);
            if (c >= 2 && c < 12) begin
                chk("s2_hold_valid", {31'd0, id_valid}, 32'd1);
                chk("s2_hold_pc", id_pc, 32'h0);
                chk("s2_hold_instr1", id_instr1, 32'h1000_0000);
            end
            if (c == 10) chk("s2_pc_stopped", {22'd0, rom_addr}, 32'd8);
            if (c >= 12 && c < 17) begin
                chk("s2_drain_valid", {31'd0, id_valid}, 32'd1);
                chk("s2_drain_pc", id_pc, 32'((c - 12) * 8));
            end
`ifdef FETCH_PERF_EN
            if (c == 31) begin
                chk("s6_stall_cnt", perf_stall_cnt, 32'd10);
                chk("s6_redirect_cnt", perf_redirect_cnt, 32'd1);
            end
`endif
            tick();
        end
        redirect_valid = 1'b0;

        // Scenario 3: redirect to 0x40 in cycle 6.
        id_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            redirect_valid = (c == 6);
            redirect_pc = 32'h40;
            @(negedge clk);
            if (c >= 6 && c <= 8) chk("s3_bubble", {31'd0, id_valid}, 32'd0);
            if (c == 9) begin
                chk("s3_instr1", id_instr1, 32'h1000_0010);
                chk("s3_instr2", id_instr2, 32'h1000_0011);
            end
            if (c >= 9) begin
                chk("s3_valid", {31'd0, id_valid}, 32'd1);
                chk("s3_pc", id_pc, 32'h40 + 32'((c - 9) * 8));
            end
            tick();
        end

        // Scenario 4: redirect to the last ROM word, odd-word target.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            redirect_valid = (c == 3);
            redirect_pc = 32'hFFE;
            @(negedge clk);
            if (c == 5) chk("s4_rom_addr", {22'd0, rom_addr}, 32'd1);
            if (c == 6) begin
                chk("s4_valid", {31'd0, id_valid}, 32'd1);
                chk("s4_pc", id_pc, 32'hFFC);
                chk("s4_instr1", id_instr1, 32'h1000_03FF);
                chk("s4_slot2", {31'd0, id_slot2_valid}, 32'd0);
            end
            if (c == 7) begin
                chk("s4_next_pc", id_pc, 32'h1004);
                chk("s4_next_instr1", id_instr1, 32'h1000_0001);
                chk("s4_next_instr2", id_instr2, 32'h1000_0002);
                chk("s4_next_slot2", {31'd0, id_slot2_valid}, 32'd1);
            end
            tick();
        end

        // Scenario 5: full queue, pop and redirect together, then reset mid-stream.
        id_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            id_ready = (c >= 6);
            redirect_valid = (c == 6);
            redirect_pc = 32'h200;
            rst = (c == 10);
            @(negedge clk);
            if (c == 5) chk("s5_full_rom_addr", {22'd0, rom_addr}, 32'd8);
            if (c == 6 || c == 7) chk("s5_flushed", {31'd0, id_valid}, 32'd0);
            if (c == 9) begin
                chk("s5_target_valid", {31'd0, id_valid}, 32'd1);
                chk("s5_target_pc", id_pc, 32'h200);
            end
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("s5_rst_valid", {31'd0, id_valid}, 32'd0);
                chk("s5_rst_rom_addr", {22'd0, rom_addr}, 32'd0);
            end
            if (c == 2) chk("s5_restart_pc", id_pc, 32'h0);
            tick();
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            id_ready = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 75 : 30));
            redirect_valid = ($urandom_range(0, 99) < 5);
            case ($urandom_range(0, 3))
                0: redirect_pc = $urandom;
                1: redirect_pc = 32'h0000_0FF0 + 32'($urandom_range(0, 15));
                2: redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: redirect_pc = 32'($urandom_range(0, 4095));
            endcase
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
